// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage sequencer: FSM encoding,
// exception codes and line/physical-address geometry.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DROP  = 3'd2,
    ST_FULL  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_PF   = 2'b01;
  localparam logic [1:0] EXC_PROT = 2'b10;

  localparam int LINE_BYTES = 32;
  localparam int PADDR_W    = 15;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch pointer, drives the TLB lookup,
// issues one I-cache line request at a time and buffers the returned line
// for decode. Redirects may arrive in any state and squash in-flight work.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | lookup active; issue line request or record a fetch fault
// ST_WAIT  | one request outstanding, its line will be buffered
// ST_DROP  | one request outstanding, its line is stale and discarded
// ST_FULL  | line buffer valid, waiting for decode to accept it
// ST_FAULT | fetch exception pending, held until a redirect
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000,
  parameter int          LINE_W    = 256,
  parameter int          PADDR_W   = fetch_pkg::PADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_eip,
  output logic               f_ren,
  output logic [31:0]        f_address,
  input  logic [2:0]         f_PFN,
  input  logic               ic_prot_exp,
  input  logic               ic_page_fault,
  output logic               ic_req,
  output logic [PADDR_W-1:0] ic_paddr,
  input  logic               ic_rdy,
  input  logic [LINE_W-1:0]  ic_line,
  output logic               out_valid,
  output logic [LINE_W-1:0]  out_line,
  output logic [31:0]        out_eip,
  input  logic               dec_ready,
  output logic               exc_valid,
  output logic [1:0]         exc_code,
  output logic [31:0]        exc_eip
);

  localparam int OFF_W = $clog2(LINE_BYTES);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0]       r_eip;
  logic              r_out_valid;
  logic [LINE_W-1:0] r_out_line;
  logic [31:0]       r_out_eip;
  logic              r_exc_valid;
  logic [1:0]        r_exc_code;
  logic [31:0]       r_exc_eip;

  logic              w_f_ren;
  logic              w_ic_req;
  logic              w_load;
  logic              w_take_fault;
  logic              w_consume;
  logic [31:0]       w_eip_next_line;

  // Next line start: bump the line index and clear the byte offset; wraps.
  assign w_eip_next_line = {r_eip[31:OFF_W] + (32-OFF_W)'(1), {OFF_W{1'b0}}};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control strobes; redirect dominates everywhere.
  always_comb begin
    w_state_nxt  = r_state;
    w_f_ren      = 1'b0;
    w_ic_req     = 1'b0;
    w_load       = 1'b0;
    w_take_fault = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_f_ren = 1'b1;
        if (redirect_valid) begin
          w_state_nxt = ST_FETCH;
        end else if (ic_prot_exp || ic_page_fault) begin
          w_take_fault = 1'b1;
          w_state_nxt  = ST_FAULT;
        end else begin
          w_ic_req    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          // A response landing with the redirect is simply dropped here.
          w_state_nxt = ic_rdy ? ST_FETCH : ST_DROP;
        end else if (ic_rdy) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_DROP: begin
        // Stay until the stale response retires, even across redirects.
        if (ic_rdy) w_state_nxt = ST_FETCH;
      end
      ST_FULL: begin
        if (redirect_valid) begin
          w_state_nxt = ST_FETCH;
        end else if (dec_ready) begin
          w_consume   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Fetch pointer, line buffer and sticky exception registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eip       <= RESET_EIP;
      r_out_valid <= 1'b0;
      r_out_line  <= '0;
      r_out_eip   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= EXC_NONE;
      r_exc_eip   <= '0;
    end else if (redirect_valid) begin
      r_eip       <= redirect_eip;
      r_out_valid <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_code  <= EXC_NONE;
    end else begin
      if (w_load) begin
        r_out_line  <= ic_line;
        r_out_eip   <= r_eip;
        r_out_valid <= 1'b1;
        r_eip       <= w_eip_next_line;
      end
      if (w_consume) r_out_valid <= 1'b0;
      if (w_take_fault) begin
        r_exc_valid <= 1'b1;
        r_exc_code  <= ic_prot_exp ? EXC_PROT : EXC_PF;
        r_exc_eip   <= r_eip;
      end
    end
  end

  // Lookup and request strobes are held low while reset is asserted.
  assign f_ren     = w_f_ren & ~rst;
  assign ic_req    = w_ic_req & ~rst;
  assign f_address = r_eip;
  assign ic_paddr  = {f_PFN, r_eip[11:OFF_W], {OFF_W{1'b0}}};

  assign out_valid = r_out_valid;
  assign out_line  = r_out_line;
  assign out_eip   = r_out_eip;
  assign exc_valid = r_exc_valid;
  assign exc_code  = r_exc_code;
  assign exc_eip   = r_exc_eip;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all compared each cycle against a flag-based model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_EIP = 32'h0000_1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_valid;
  logic [31:0]  redirect_eip;
  logic         f_ren;
  logic [31:0]  f_address;
  logic [2:0]   f_PFN;
  logic         ic_prot_exp;
  logic         ic_page_fault;
  logic         ic_req;
  logic [14:0]  ic_paddr;
  logic         ic_rdy;
  logic [255:0] ic_line;
  logic         out_valid;
  logic [255:0] out_line;
  logic [31:0]  out_eip;
  logic         dec_ready;
  logic         exc_valid;
  logic [1:0]   exc_code;
  logic [31:0]  exc_eip;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_EIP(RST_EIP), .LINE_W(256), .PADDR_W(15)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_eip(redirect_eip),
    .f_ren(f_ren), .f_address(f_address), .f_PFN(f_PFN),
    .ic_prot_exp(ic_prot_exp), .ic_page_fault(ic_page_fault),
    .ic_req(ic_req), .ic_paddr(ic_paddr), .ic_rdy(ic_rdy), .ic_line(ic_line),
    .out_valid(out_valid), .out_line(out_line), .out_eip(out_eip),
    .dec_ready(dec_ready),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_eip(exc_eip)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  // Model: a request in flight (possibly stale), a buffered line, a fault.
  logic [31:0]  m_eip;
  bit           m_outstanding;
  bit           m_stale;
  bit           m_buf_valid;
  logic [255:0] m_buf_line;
  logic [31:0]  m_buf_eip;
  bit           m_fault;
  logic [1:0]   m_code;
  logic [31:0]  m_exc_eip;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit m_fetching();
    return !rst && !m_outstanding && !m_buf_valid && !m_fault;
  endfunction

  task automatic compare_all();
    bit fe, rq;
    fe = m_fetching();
    rq = fe && !redirect_valid && !ic_prot_exp && !ic_page_fault;
    check("f_ren", f_ren, fe);
    if (fe) check("f_address", f_address, m_eip);
    check("ic_req", ic_req, rq);
    if (rq) check("ic_paddr", ic_paddr, {f_PFN, m_eip[11:5], 5'b0});
    check("out_valid", out_valid, m_buf_valid);
    check("out_line", out_line, m_buf_line);
    check("out_eip", out_eip, m_buf_eip);
    check("exc_valid", exc_valid, m_fault);
    check("exc_code", exc_code, m_code);
    check("exc_eip", exc_eip, m_exc_eip);
  endtask

  task automatic model_update();
    bit fe;
    fe = m_fetching();
    if (rst) begin
      m_eip = RST_EIP; m_outstanding = 0; m_stale = 0; m_buf_valid = 0;
      m_buf_line = '0; m_buf_eip = '0; m_fault = 0; m_code = 2'b00; m_exc_eip = '0;
    end else if (redirect_valid) begin
      m_eip = redirect_eip; m_buf_valid = 0; m_fault = 0; m_code = 2'b00;
      if (m_outstanding) begin
        if (ic_rdy) begin m_outstanding = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else if (m_outstanding && ic_rdy) begin
      if (!m_stale) begin
        m_buf_valid = 1; m_buf_line = ic_line; m_buf_eip = m_eip;
        m_eip = {m_eip[31:5] + 27'd1, 5'b0};
      end
      m_outstanding = 0; m_stale = 0;
    end else if (m_buf_valid && dec_ready) begin
      m_buf_valid = 0;
    end else if (fe) begin
      if (ic_prot_exp)        begin m_fault = 1; m_code = 2'b10; m_exc_eip = m_eip; end
      else if (ic_page_fault) begin m_fault = 1; m_code = 2'b01; m_exc_eip = m_eip; end
      else m_outstanding = 1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit was_rst;
    #1;
    if (armed) compare_all();
    was_rst = rst;
    @(posedge clk);
    model_update();
    if (was_rst) armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    redirect_valid = 0; redirect_eip = '0; f_PFN = 3'd3;
    ic_prot_exp = 0; ic_page_fault = 0; ic_rdy = 0; ic_line = '0; dec_ready = 0;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  localparam logic [255:0] L1 = {8{32'hA5A5_0001}};
  localparam logic [255:0] L2 = {8{32'hA5A5_0002}};
  localparam logic [255:0] L3 = {8{32'hA5A5_0003}};
  localparam logic [255:0] L4 = {8{32'hA5A5_0004}};
  localparam logic [255:0] L5 = {8{32'hA5A5_0005}};
  localparam logic [255:0] LS = {8{32'hDEAD_BEEF}};

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    step(); step();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_f_ren", f_ren, 1'b0);
    rst = 0;

    // Sequential fetch from reset, PFN 3.
    dec_ready = 1;
    #1;
    check("s1_req0", ic_req, 1'b1);
    check("s1_paddr0", ic_paddr, 15'h3000);
    step();
    ic_rdy = 1; ic_line = L1;
    #1; check("s1_ov_t1", out_valid, 1'b0);
    step();
    ic_rdy = 0;
    #1;
    check("s1_ov_t2", out_valid, 1'b1);
    check("s1_eip0", out_eip, 32'h1000);
    check("s1_line0", out_line, L1);
    step();
    #1; check("s1_paddr1", ic_paddr, 15'h3020);
    step();
    ic_rdy = 1; ic_line = L2;
    step();
    ic_rdy = 0; dec_ready = 0;
    #1; check("s1_eip1", out_eip, 32'h1020);

    // Redirect while the buffer is full.
    redirect_valid = 1; redirect_eip = 32'h1234;
    step();
    redirect_valid = 0;
    #1;
    check("s2_ov_drop", out_valid, 1'b0);
    check("s2_faddr", f_address, 32'h1234);
    check("s2_paddr", ic_paddr, 15'h3220);
    step();
    ic_rdy = 1; ic_line = L3;
    step();
    ic_rdy = 0;
    #1; check("s2_eip", out_eip, 32'h1234);
    dec_ready = 1;
    step();

    // Redirect while a request is in flight; stale line arrives 3 cycles on.
    step();
    redirect_valid = 1; redirect_eip = 32'h2000;
    step();
    redirect_valid = 0;
    step(); step();
    ic_rdy = 1; ic_line = LS;
    #1; check("s3_noreq_drop", ic_req, 1'b0);
    step();
    ic_rdy = 0;
    #1;
    check("s3_req", ic_req, 1'b1);
    check("s3_faddr", f_address, 32'h2000);
    step();
    ic_rdy = 1; ic_line = L4;
    step();
    ic_rdy = 0;
    #1;
    check("s3_line", out_line, L4);
    check("s3_eip", out_eip, 32'h2000);
    step();

    // Page fault at 0x5000.
    redirect_valid = 1; redirect_eip = 32'h5000;
    step();
    redirect_valid = 0; ic_page_fault = 1;
    #1; check("s4_noreq", ic_req, 1'b0);
    step();
    ic_page_fault = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s4_exc_valid", exc_valid, 1'b1);
      check("s4_exc_code", exc_code, 2'b01);
      check("s4_exc_eip", exc_eip, 32'h5000);
      check("s4_noreq_hold", ic_req, 1'b0);
      step();
    end
    redirect_valid = 1; redirect_eip = 32'h6000;
    step();
    redirect_valid = 0;
    #1;
    check("s4_exc_clr", exc_valid, 1'b0);
    check("s4_code_clr", exc_code, 2'b00);

    // Protection beats page fault.
    ic_prot_exp = 1; ic_page_fault = 1;
    step();
    ic_prot_exp = 0; ic_page_fault = 0;
    #1; check("s5_exc_code", exc_code, 2'b10);
    redirect_valid = 1; redirect_eip = 32'h7000;
    step();
    redirect_valid = 0;

    // Decode stalls, a stray response is ignored, then redirect + accept.
    dec_ready = 0;
    step();
    ic_rdy = 1; ic_line = L5;
    step();
    ic_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin ic_rdy = 1; ic_line = LS; end
      #1;
      check("s6_line_hold", out_line, L5);
      check("s6_noreq", ic_req, 1'b0);
      step();
      ic_rdy = 0;
    end
    redirect_valid = 1; redirect_eip = 32'h8000; dec_ready = 1;
    step();
    redirect_valid = 0;
    #1;
    check("s6_ov_flush", out_valid, 1'b0);
    check("s6_faddr", f_address, 32'h8000);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_eip   = $urandom;
      f_PFN          = 3'($urandom_range(0, 7));
      ic_page_fault  = ($urandom_range(0, 15) == 0);
      ic_prot_exp    = ($urandom_range(0, 31) == 0);
      dec_ready      = 1'($urandom_range(0, 1));
      ic_rdy         = m_outstanding && ($urandom_range(0, 2) == 0);
      ic_line        = rand_line();
      step();
    end

    idle();
    rst = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the fetch pointer (EIP) and drives the combinational fetch TLB lookup with a read-enable and virtual address.
- Consumes the lookup's PFN and exception flags, issues 32-byte-line read requests to the I-cache, and holds one returned line in an output buffer for decode.
- Handles redirects from later stages, including squashing an I-cache response that is still in flight.

Parameters:
- RESET_EIP, 32'h0000_0000, fetch pointer value loaded on reset
- LINE_W, 256, I-cache line width in bits (32 bytes)
- PADDR_W, 15, physical address width: {PFN[2:0], offset[11:0]}

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- redirect_valid  in  1  redirect request from execute/retire
- redirect_eip  in  32  redirect target
- f_ren  out  1  lookup enable to the TLB lookup
- f_address  out  32  virtual fetch address to the TLB lookup
- f_PFN  in  3  PFN returned by the lookup, same cycle
- ic_prot_exp  in  1  CS-limit violation from the lookup
- ic_page_fault  in  1  TLB miss from the lookup
- ic_req  out  1  I-cache line request, one-cycle pulse
- ic_paddr  out  15  physical line address, low 5 bits zero
- ic_rdy  in  1  I-cache response valid, one cycle
- ic_line  in  LINE_W  I-cache line data
- out_valid  out  1  line buffer valid to decode
- out_line  out  LINE_W  buffered line
- out_eip  out  32  EIP of the first valid byte in out_line
- dec_ready  in  1  decode accepts the buffer
- exc_valid  out  1  fetch exception pending (sticky)
- exc_code  out  2  01 = page fault, 10 = protection; 00 when none
- exc_eip  out  32  faulting EIP

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Reset: state = FETCH, eip = RESET_EIP, and the following outputs are 0: out_valid, exc_valid, exc_code, ic_req, f_ren, out_line, out_eip, exc_eip.
- FSM states: FETCH, WAIT, DROP, FULL, FAULT.
- FETCH:
  - f_ren = 1 and f_address = eip (combinational); all other states drive f_ren = 0.
  - If ic_prot_exp: go to FAULT with exc_code = 10. Protection has priority over page fault.
  - Else if ic_page_fault: go to FAULT with exc_code = 01.
  - Else: ic_req = 1, ic_paddr = {f_PFN, eip[11:5], 5'b0}; go to WAIT.
- WAIT, on ic_rdy:
  - out_line <= ic_line, out_eip <= eip, out_valid <= 1.
  - eip <= {eip[31:5] + 1, 5'b0}; the 27-bit increment wraps silently.
  - Go to FULL.
- FULL:
  - When dec_ready (out_valid & dec_ready = transfer): out_valid <= 0, go to FETCH.
  - There is no prefetch; at most one request is outstanding.
- FAULT:
  - exc_valid = 1 and exc_eip = eip are held; no requests are issued.
  - Exit only via redirect or reset.
- Redirect (highest priority, any state):
  - eip <= redirect_eip; out_valid <= 0; exc_valid <= 0; exc_code <= 0.
  - From WAIT with ic_rdy low: go to DROP.
  - From WAIT with ic_rdy high in the same cycle: the response is discarded; go to FETCH.
  - All other states: go to FETCH.
- DROP: wait for ic_rdy, discard the data, then go to FETCH.
  - A redirect while in DROP updates eip and stays in DROP.
- Redirect and dec_ready in the same cycle: the redirect wins; the buffer is flushed and not counted as consumed.
- Latency: the FETCH cycle is t; the earliest ic_rdy is t+1; out_valid rises at t+2.
- Reset mid-WAIT: the in-flight I-cache response is the cache's responsibility; the cache also resets on rst, so fetch_ctrl returns to FETCH with no drop.
- ic_rdy arriving in FETCH, FULL or FAULT is a protocol error and is ignored.

Decomposition:
- Shared fetch package holds:
  - state encoding (3-bit enum: FETCH, WAIT, DROP, FULL, FAULT)
  - exception codes EXC_NONE = 2'b00, EXC_PF = 2'b01, EXC_PROT = 2'b10
  - LINE_BYTES = 32 and PADDR_W
- No sub-module; a single FSM plus datapath registers. The top-level fetch wrapper instantiates this block next to the TLB lookup.

Test Plan:
- Reset with RESET_EIP = 0x1000, mapped PFN = 3, ic_rdy one cycle after req, dec_ready = 1 → ic_paddr = 0x3000, then 0x3020. out_eip = 0x1000, then 0x1020. out_valid rises 2 cycles after each req.
- Redirect to 0x1234 in FULL → out_valid drops the next cycle; next f_address = 0x1234; ic_paddr = {PFN, 7'h11, 5'b0}; out_eip = 0x1234.
- Redirect during WAIT, with ic_rdy 3 cycles later → state goes to DROP; the stale line never appears on out_line. The new request issues on the cycle after ic_rdy.
- TLB miss (ic_page_fault = 1) at eip 0x5000 → exc_valid = 1, exc_code = 01, exc_eip = 0x5000, no ic_req. This holds until a redirect, which clears exc_valid.
- ic_prot_exp and ic_page_fault both high → exc_code = 10.
- dec_ready held low for 5 cycles in FULL → out_line is stable and no ic_req is issued. Redirect and dec_ready together → the buffer is flushed and the FSM goes to FETCH at the redirect target.
